// File: rtl/pool_pkg.sv
// Shared types for the streaming max-pool stage: sample type, output beat payload
// and the signed max helper used by the single comparator.
package pool_pkg;

  localparam int unsigned DATA_W = 16;

  typedef logic signed [DATA_W-1:0] sample_t;

  // One pooled result as it travels through the output register.
  typedef struct packed {
    sample_t data;
    logic    last;
  } pool_beat_t;

  // Signed maximum; on equality either operand is the same value.
  function automatic sample_t smax(sample_t a, sample_t b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_out_reg.sv
// One-entry valid/ready output register. A load always wins; an output accept
// without a load empties the slot. Contents are frozen while valid & !ready.
module pool_out_reg
  import pool_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  pool_beat_t load_beat,
  input  logic       ready,
  output logic       valid,
  output pool_beat_t beat
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      beat  <= '0;
    end else if (load) begin
      // The upstream only loads when the slot is empty or being drained this cycle.
      valid <= 1'b1;
      beat  <= load_beat;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pool: non-overlapping windows of POOL samples over a LENY-sample
// vector; the partial tail window is consumed and dropped.
module maxpool_stream
  import pool_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned POOL  = 2,
  parameter int unsigned LENY  = 13
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_y,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  output logic signed [WIDTH-1:0] m_data_out_z,
  output logic                    m_valid_z,
  input  logic                    m_ready_z,
  output logic                    m_last_z
);

  localparam int unsigned NOUT   = LENY / POOL;
  localparam int unsigned BODY   = NOUT * POOL;
  localparam int unsigned IDX_W  = $clog2(LENY + 1);
  localparam int unsigned WCNT_W = $clog2(POOL);

  logic [IDX_W-1:0]  idx;
  logic [WCNT_W-1:0] wcnt;
  sample_t           runmax;

  sample_t    x_c;
  sample_t    max_c;
  logic       in_body_c;
  logic       win_first_c;
  logic       win_end_c;
  logic       vec_end_c;
  logic       in_acc_c;
  logic       load_c;
  pool_beat_t load_beat_c;
  pool_beat_t out_beat;

  // Window/vector position decode and the single shared comparator.
  always_comb begin
    x_c         = DATA_W'(s_data_in_y);
    max_c       = smax(runmax, x_c);
    in_body_c   = (idx < IDX_W'(BODY));
    win_first_c = (wcnt == '0);
    win_end_c   = (wcnt == WCNT_W'(POOL - 1));
    vec_end_c   = (idx == IDX_W'(LENY - 1));
  end

  // Only a window-closing sample needs room in the output register.
  assign s_ready_y = !(win_end_c && in_body_c) || !m_valid_z || m_ready_z;
  assign in_acc_c  = s_valid_y && s_ready_y;
  assign load_c    = in_acc_c && in_body_c && win_end_c;

  always_comb begin
    load_beat_c      = '0;
    load_beat_c.data = max_c;
    load_beat_c.last = (idx == IDX_W'(BODY - 1));
  end

  // Position counters; both restart at the vector boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      wcnt <= '0;
    end else if (in_acc_c) begin
      if (vec_end_c) begin
        idx  <= '0;
        wcnt <= '0;
      end else begin
        idx  <= idx + IDX_W'(1);
        wcnt <= win_end_c ? '0 : wcnt + WCNT_W'(1);
      end
    end
  end

  // Running maximum of the open window; tail samples leave it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      runmax <= '0;
    end else if (in_acc_c && in_body_c) begin
      runmax <= win_first_c ? x_c : max_c;
    end
  end

  pool_out_reg u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (load_c),
    .load_beat (load_beat_c),
    .ready     (m_ready_z),
    .valid     (m_valid_z),
    .beat      (out_beat)
  );

  assign m_data_out_z = WIDTH'(out_beat.data);
  assign m_last_z     = out_beat.last;

endmodule
